matvec_engine: RTL and testbench

//  Parametrised matrix-vector multiply engine: computes C = A x B for a ROWS x COLS matrix A and a COLS-entry vector B.

---
 rtl/matvec_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_matvec_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_engine.sv
// matvec_engine: C = A x B for a ROWS x COLS matrix A and a COLS-entry vector B.
// Operands arrive one packed word per read. B is read first, then each row of A.
// ROWS MAC lanes then step through one column per cycle. The lanes support
// signed or unsigned operands, accumulate onto the previous result, and optional
// saturation.
module matvec_engine #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 32,
    parameter int SAT    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode_signed,
    input  logic                     acc_en,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_req,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic                     rd_gnt,
    input  logic                     rd_valid,
    input  logic [COLS*DATA_W-1:0]   rd_data,
    output logic [ROWS*ACC_W-1:0]    c_out
);

    localparam int IW = $clog2(ROWS + 1);
    localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = 2 * DATA_W + 2;   // product of two (DATA_W+1)-bit signed operands
    localparam int SW = ACC_W + 2;        // adder width with headroom for overflow detection

    localparam logic [IW-1:0] LAST_IDX = IW'(ROWS);
    localparam logic [KW-1:0] LAST_K   = KW'(COLS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILL_BUF  = 3'd1;
    localparam logic [2:0] S_FILL_ROWS = 3'd2;
    localparam logic [2:0] S_CALC      = 3'd3;
    localparam logic [2:0] S_WAIT      = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [IW-1:0]           fetch_idx_q, fetch_idx_d;   // 0 = B word, r+1 = row r
    logic [KW-1:0]           k_q, k_d;
    logic                    rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic                    outst_q, outst_d;           // granted, data not yet returned
    logic [ADDR_W-1:0]       base_q, base_d;
    logic                    signed_q, signed_d;
    logic                    acc_en_q, acc_en_d;
    logic [COLS*DATA_W-1:0]  b_q, b_d;

    logic in_fill;
    logic cap;
    logic enter_calc;

    assign in_fill    = (state_q == S_FILL_BUF) || (state_q == S_FILL_ROWS);
    // Data is taken only for the request in flight; stray rd_valid is dropped.
    assign cap        = in_fill && rd_valid && (outst_q || (rd_req_q && rd_gnt));
    assign enter_calc = cap && (state_q == S_FILL_ROWS) && (fetch_idx_q == LAST_IDX);

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign rd_req  = rd_req_q;
    assign rd_addr = rd_addr_q;

    // Next-state logic for the sequencer and the single-outstanding read port
    always_comb begin
        state_d     = state_q;
        fetch_idx_d = fetch_idx_q;
        k_d         = k_q;
        rd_req_d    = rd_req_q;
        rd_addr_d   = rd_addr_q;
        outst_d     = outst_q;
        base_d      = base_q;
        signed_d    = signed_q;
        acc_en_d    = acc_en_q;
        b_d         = b_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FILL_BUF;
                    base_d      = base_addr;
                    signed_d    = mode_signed;
                    acc_en_d    = acc_en;
                    fetch_idx_d = '0;
                end
            end
            S_FILL_BUF, S_FILL_ROWS: begin
                if (rd_req_q && rd_gnt) begin
                    rd_req_d = 1'b0;
                    outst_d  = 1'b1;
                end
                if (cap) begin
                    outst_d     = 1'b0;
                    fetch_idx_d = fetch_idx_q + 1'b1;
                    if (state_q == S_FILL_BUF) begin
                        b_d     = rd_data;
                        state_d = S_FILL_ROWS;
                    end else if (fetch_idx_q == LAST_IDX) begin
                        state_d = S_CALC;
                        k_d     = '0;
                    end
                end
                // A new request goes out only once the previous data has returned.
                if (!rd_req_q && !outst_q) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = base_q + ADDR_W'(fetch_idx_q);
                end
            end
            S_CALC: begin
                k_d = k_q + 1'b1;
                if (k_q == LAST_K) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer and read-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fetch_idx_q <= '0;
            k_q         <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            outst_q     <= 1'b0;
            base_q      <= '0;
            signed_q    <= 1'b0;
            acc_en_q    <= 1'b0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            fetch_idx_q <= fetch_idx_d;
            k_q         <= k_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            outst_q     <= outst_d;
            base_q      <= base_d;
            signed_q    <= signed_d;
            acc_en_q    <= acc_en_d;
            b_q         <= b_d;
        end
    end

    logic [DATA_W-1:0] b_el;
    logic signed [DATA_W:0] b_ext;
    assign b_el  = b_q[k_q*DATA_W +: DATA_W];
    assign b_ext = {signed_q & b_el[DATA_W-1], b_el};

    // One MAC lane per row: row buffer, product register, accumulator, result.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
        localparam logic [IW-1:0] MY_IDX = IW'(gi + 1);

        logic [COLS*DATA_W-1:0] row_q;
        logic signed [PW-1:0]   prod_q;
        logic signed [PW-1:0]   prod_d;
        logic [ACC_W-1:0]       acc_q;
        logic [ACC_W-1:0]       acc_d;
        logic [ACC_W-1:0]       c_q;
        logic [DATA_W-1:0]      a_el;
        logic signed [DATA_W:0] a_ext;
        logic signed [PW-1:0]   a_w;
        logic signed [PW-1:0]   b_w;
        logic signed [SW-1:0]   acc_x;
        logic signed [SW-1:0]   prod_x;
        logic signed [SW-1:0]   sum_x;

        assign a_el   = row_q[k_q*DATA_W +: DATA_W];
        assign a_ext  = {signed_q & a_el[DATA_W-1], a_el};
        assign a_w    = {{(PW-DATA_W-1){a_ext[DATA_W]}}, a_ext};
        assign b_w    = {{(PW-DATA_W-1){b_ext[DATA_W]}}, b_ext};
        assign prod_d = a_w * b_w;
        assign acc_x  = signed_q ? {{2{acc_q[ACC_W-1]}}, acc_q} : {2'b00, acc_q};
        assign prod_x = {{(SW-PW){prod_q[PW-1]}}, prod_q};
        assign sum_x  = acc_x + prod_x;

        // Accumulator update with optional clamping to the signed/unsigned range
        always_comb begin
            acc_d = sum_x[ACC_W-1:0];
            if (SAT != 0) begin
                if (signed_q) begin
                    if (sum_x[SW-1] && !(sum_x[ACC_W] && sum_x[ACC_W-1]))
                        acc_d = {1'b1, {(ACC_W-1){1'b0}}};
                    else if (!sum_x[SW-1] && (sum_x[ACC_W] || sum_x[ACC_W-1]))
                        acc_d = {1'b0, {(ACC_W-1){1'b1}}};
                end else begin
                    if (sum_x[SW-1])
                        acc_d = '0;
                    else if (sum_x[ACC_W])
                        acc_d = '1;
                end
            end
        end

        // Row capture, MAC pipeline and result latch for this lane
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                row_q  <= '0;
                prod_q <= '0;
                acc_q  <= '0;
                c_q    <= '0;
            end else begin
                if (cap && (state_q == S_FILL_ROWS) && (fetch_idx_q == MY_IDX))
                    row_q <= rd_data;
                if (enter_calc) begin
                    // Zero product means the first CALC add leaves the seed untouched.
                    acc_q  <= acc_en_q ? c_q : '0;
                    prod_q <= '0;
                end else if (state_q == S_CALC) begin
                    acc_q  <= acc_d;
                    prod_q <= prod_d;
                end else if (state_q == S_WAIT) begin
                    // Last product drains here; the result is visible during DONE.
                    acc_q <= acc_d;
                    c_q   <= acc_d;
                end
            end
        end

        assign c_out[gi*ACC_W +: ACC_W] = c_q;
    end

endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine: one default instance and one saturating
// 18-bit instance share a single memory responder selected by 'sel'.
module tb_matvec_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int AW0  = 24;
    localparam int AW1  = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, mode_signed, acc_en;
    logic [31:0] base_addr;
    logic        rd_gnt, rd_valid;
    logic [63:0] rd_data;
    int          sel;

    logic busy0, done0, rd_req0, busy1, done1, rd_req1;
    logic [31:0] rd_addr0, rd_addr1;
    logic [ROWS*AW0-1:0] c0;
    logic [ROWS*AW1-1:0] c1;

    logic start0, start1, gnt0, gnt1, val0, val1;
    logic rd_req_s, done_s;
    logic [31:0] rd_addr_s;

    assign start0    = start && (sel == 0);
    assign start1    = start && (sel == 1);
    assign gnt0      = rd_gnt && (sel == 0);
    assign gnt1      = rd_gnt && (sel == 1);
    assign val0      = rd_valid && (sel == 0);
    assign val1      = rd_valid && (sel == 1);
    assign rd_req_s  = (sel == 0) ? rd_req0 : rd_req1;
    assign rd_addr_s = (sel == 0) ? rd_addr0 : rd_addr1;
    assign done_s    = (sel == 0) ? done0 : done1;

    matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_W(8), .ACC_W(AW0), .ADDR_W(32), .SAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode_signed(mode_signed), .acc_en(acc_en),
        .base_addr(base_addr), .busy(busy0), .done(done0), .rd_req(rd_req0), .rd_addr(rd_addr0),
        .rd_gnt(gnt0), .rd_valid(val0), .rd_data(rd_data), .c_out(c0));

    matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_W(8), .ACC_W(AW1), .ADDR_W(32), .SAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode_signed(mode_signed), .acc_en(acc_en),
        .base_addr(base_addr), .busy(busy1), .done(done1), .rd_req(rd_req1), .rd_addr(rd_addr1),
        .rd_gnt(gnt1), .rd_valid(val1), .rd_data(rd_data), .c_out(c1));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [63:0] mem [0:63];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder state
    int  lat_max = 0;
    int  gd_fix  = -1;
    bit  spur    = 1'b0;
    int  vcnt    = -1;
    int  gcnt    = -1;
    bit  just_gnt = 1'b0;
    int  ovl     = 0;
    int  nvalid  = 0;
    int  ndone   = 0;
    int  cur_base = 0;
    bit  last_seen = 1'b0;
    int  last_cyc = 0;
    int  done_cyc = 0;
    logic [31:0] paddr = '0;

    // Memory responder: variable grant/data delay, protocol watch, spurious valids
    initial begin
        rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(negedge clk);
            rd_gnt = 1'b0;
            rd_valid = 1'b0;
            if (just_gnt && rd_req_s) ovl++;                 // rd_req held past its grant
            else if (vcnt >= 0 && rd_req_s) ovl++;           // second request while one outstanding
            just_gnt = 1'b0;
            if (vcnt > 0) begin
                vcnt--;
            end else if (vcnt == 0) begin
                rd_valid = 1'b1;
                rd_data  = mem[paddr[5:0]];
                nvalid++;
                if (paddr == 32'(cur_base + ROWS)) begin
                    last_seen = 1'b1;
                    last_cyc  = cyc;
                end
                vcnt = -1;
            end else if (rd_req_s) begin
                if (gcnt < 0) gcnt = (gd_fix >= 0) ? gd_fix : int'($urandom_range(lat_max, 0));
                if (gcnt == 0) begin
                    rd_gnt   = 1'b1;
                    paddr    = rd_addr_s;
                    vcnt     = int'($urandom_range(lat_max, 0));
                    gcnt     = -1;
                    just_gnt = 1'b1;
                end else begin
                    gcnt--;
                end
            end else begin
                gcnt = -1;
                if (spur) begin
                    rd_valid = 1'b1;
                    rd_data  = {$urandom, $urandom};
                end
            end
        end
    end

    // done pulse monitor
    initial begin
        forever begin
            @(negedge clk);
            if (done_s) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    task automatic launch(input bit sg, input bit ae, input int base);
        @(negedge clk);
        ndone = 0; nvalid = 0; last_seen = 1'b0; cur_base = base;
        mode_signed = sg; acc_en = ae; base_addr = 32'(base); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && ndone == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, " done count"}, 64'(ndone), 64'd1);
    endtask

    task automatic check_c0(input string tag, input logic [23:0] unit, input bit scale);
        for (int r = 0; r < ROWS; r++)
            check($sformatf("%s c0[%0d]", tag, r), 64'(c0[r*AW0 +: AW0]),
                  scale ? 64'(unit * (r + 1)) : 64'(unit));
    endtask

    task automatic check_c1(input string tag, input logic [17:0] val);
        for (int r = 0; r < ROWS; r++)
            check($sformatf("%s c1[%0d]", tag, r), 64'(c1[r*AW1 +: AW1]), 64'(val));
    endtask

    task automatic load_fill(input int base, input logic [7:0] bb, input logic [7:0] ab);
        mem[base] = {8{bb}};
        for (int r = 0; r < ROWS; r++) mem[base + 1 + r] = {8{ab}};
    endtask

    initial begin
        logic [63:0] w;
        rst_n = 1'b0; start = 1'b0; mode_signed = 1'b0; acc_en = 1'b0; base_addr = '0; sel = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int k = 0; k < COLS; k++) w[k*8 +: 8] = 8'(k + 1);
        mem[0] = w;
        for (int r = 0; r < ROWS; r++) mem[1 + r] = {8{8'(r + 1)}};
        load_fill(16, 8'h02, 8'hFF);
        load_fill(32, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);

        check("rst busy0", 64'(busy0), 0);
        check("rst done0", 64'(done0), 0);
        check("rst rd_req0", 64'(rd_req0), 0);
        check("rst rd_addr0", 64'(rd_addr0), 0);
        check("rst c0", 64'(|c0), 0);
        check("rst busy1", 64'(busy1), 0);
        check("rst c1", 64'(|c1), 0);
        rst_n = 1'b1;

        // 1: unsigned, zero latency
        launch(0, 0, 0); wait_done("t1");
        check_c0("t1", 24'h24, 1);
        check("t1 busy after", 64'(busy0), 0);

        // 2: accumulate, then plain again
        launch(0, 1, 0); wait_done("t2a"); check_c0("t2a", 24'h48, 1);
        launch(0, 0, 0); wait_done("t2b"); check_c0("t2b", 24'h24, 1);

        // 3: signed vs unsigned
        launch(1, 0, 16); wait_done("t3s"); check_c0("t3s", 24'hFFFFF0, 0);
        launch(0, 0, 16); wait_done("t3u"); check_c0("t3u", 24'h000FF0, 0);

        // 4: saturating 18-bit instance
        sel = 1;
        launch(0, 0, 32); wait_done("t4u"); check_c1("t4u", 18'h3FFFF);
        launch(1, 0, 32); wait_done("t4s"); check_c1("t4s", 18'h00008);

        // 5: spurious valids in IDLE, then random back-pressure
        sel = 0;
        check("t5 pre c0[0]", 64'(c0[0 +: AW0]), 64'h0FF0);
        spur = 1'b1; repeat (6) @(negedge clk); spur = 1'b0;
        @(negedge clk);
        check("t5 spur c0[0]", 64'(c0[0 +: AW0]), 64'h0FF0);
        check("t5 spur busy", 64'(busy0), 0);
        lat_max = 5; ovl = 0;
        launch(0, 0, 0); wait_done("t5");
        check_c0("t5", 24'h24, 1);
        check("t5 protocol violations", 64'(ovl), 0);
        check("t5 latency", 64'(done_cyc - last_cyc), 64'(COLS + 2));

        // 6a: start pulsed during CALC is ignored
        lat_max = 0;
        launch(0, 0, 0);
        for (int i = 0; i < 200 && !last_seen; i++) @(negedge clk);
        check("t6 reached calc", 64'(last_seen), 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("t6a");
        check_c0("t6a", 24'h24, 1);
        check("t6a no requeue busy", 64'(busy0), 0);

        // 6b: reset in FILL_ROWS with rd_req held
        gd_fix = 4;
        launch(0, 0, 0);
        for (int i = 0; i < 300 && !(nvalid >= 4 && rd_req_s); i++) @(negedge clk);
        check("t6b pre busy", 64'(busy0), 1);
        check("t6b pre rd_req", 64'(rd_req0), 1);
        rst_n = 1'b0;
        #1;
        check("t6b rst busy", 64'(busy0), 0);
        check("t6b rst rd_req", 64'(rd_req0), 0);
        check("t6b rst c0", 64'(|c0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; gd_fix = -1;
        repeat (3) @(negedge clk);
        check("t6b idle busy", 64'(busy0), 0);
        launch(0, 0, 0); wait_done("t6c");
        check_c0("t6c", 24'h24, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
